acc_host_driver: RTL and testbench
==================================

ACC_HOST_DRIVER -- requirements
Module: acc_host_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of instruction words held; power of two, at least 2.
REQ-002 Parameter RD_OPCODE, default 4'h5, is the value of bits [63:60] that marks a result-read instruction.
REQ-003 Parameter RD_LATENCY, default 2, is the number of cycles from issuing a read to accelerator_output being valid; range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
REQ-006 host_instr  input  64  instruction word from the host.
REQ-007 host_valid  input  1  host_instr is valid.
REQ-008 host_ready  output  1  driver accepts host_instr this cycle.
REQ-009 acc_instr  output  64  instruction word driven to the accelerator's accelerator_input.
REQ-010 acc_instr_valid  output  1  one-cycle strobe: acc_instr is a new word.
REQ-011 buffer_full  input  1  accelerator instruction buffer full; back-pressure.
REQ-012 accelerator_output  input  32  accelerator result bus.
REQ-013 res_data  output  32  captured result to the host.
REQ-014 res_valid  output  1  res_data is valid.
REQ-015 res_ready  input  1  host consumes res_data.
REQ-016 fifo_count  output  clog2(FIFO_DEPTH)+1  words currently queued.

Function
REQ-017 The driver SHALL use a FIFO: host_ready = (fifo_count < FIFO_DEPTH); a word is pushed when host_valid and host_ready are both 1.
REQ-018 A full FIFO SHALL keep host_ready at 0 even when a pop occurs in the same cycle; no same-cycle refill at full.
REQ-019 Push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave fifo_count unchanged and preserve word order.
REQ-020 The state machine SHALL have three states: IDLE, WAIT_RD and HOLD_RES.
REQ-021 In IDLE, with the FIFO non-empty and buffer_full sampled 0 in the same cycle, the driver SHALL pop the head word, register it onto acc_instr and assert acc_instr_valid for exactly one cycle.
REQ-022 Non-read words SHALL be issued back to back, one per cycle, while the IDLE conditions hold.
REQ-023 When buffer_full is 1, the driver SHALL issue nothing; acc_instr SHALL hold its last value and acc_instr_valid SHALL be 0.
REQ-024 When the issued word has bits [63:60] == RD_OPCODE, the state SHALL change to WAIT_RD and a down-counter SHALL load RD_LATENCY.
REQ-025 In WAIT_RD, the driver SHALL issue no words; the counter SHALL decrement once per cycle.
REQ-026 When the counter reaches 0 (RD_LATENCY cycles after the acc_instr_valid cycle), res_data SHALL capture accelerator_output, res_valid SHALL be set and the state SHALL change to HOLD_RES.
REQ-027 In HOLD_RES, res_valid and res_data SHALL hold stable until res_valid and res_ready are both 1; the state SHALL then return to IDLE and res_valid SHALL clear on the next cycle.
REQ-028 No issue SHALL occur in the cycle that HOLD_RES exits; issue resumes from IDLE on the following cycle.
REQ-029 Host pushes SHALL continue in all states, subject to REQ-017.
REQ-030 At most one read SHALL be outstanding at any time.
REQ-031 fifo_count SHALL never exceed FIFO_DEPTH, and the FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 While rst = 0, the driver SHALL hold: state IDLE, FIFO empty (fifo_count 0), acc_instr 0, acc_instr_valid 0, res_data 0, res_valid 0, counter 0, host_ready 1.
REQ-033 Asserting reset mid-operation SHALL discard queued words and any pending read with no further strobe; the first issue after deassertion occurs at least one cycle after a push.

Verification
REQ-034 Reset, then push 3 non-read words A, B, C with buffer_full = 0 -> acc_instr_valid high on 3 consecutive cycles carrying A, B, C in order; fifo_count returns to 0.
REQ-035 Push 5 words with FIFO_DEPTH 4 while buffer_full = 1 -> host_ready goes 0 after the 4th push; the 5th word is held off until buffer_full drops; no acc_instr_valid while buffer_full = 1.
REQ-036 Issue a word with [63:60] = 4'h5, with accelerator_output = 32'hDEADBEEF exactly 2 cycles later -> res_valid = 1 with res_data = 32'hDEADBEEF; a queued word behind it is not issued until res_ready is pulsed.
REQ-037 Hold res_ready = 0 for 10 cycles during HOLD_RES -> res_data stays stable; the FIFO accepts pushes up to full; after res_ready = 1, issue resumes one cycle later.
REQ-038 Drive simultaneous push and pop with fifo_count = 2 -> fifo_count stays 2 and order is preserved across pointer wrap.
REQ-039 Assert rst = 0 during WAIT_RD with 2 words queued -> all outputs at reset values; no stale res_valid and no issue after release until new pushes.

Source files
------------

// File: rtl/acc_host_driver.sv
// acc_host_driver
//   Queues 64-bit host instruction words in a small FIFO and issues them to
//   an accelerator one per cycle, honouring the accelerator's buffer_full
//   back-pressure. A word whose top nibble equals RD_OPCODE is a result read:
//   issue stalls for RD_LATENCY cycles, the accelerator result is captured,
//   and it is held for the host until res_ready is seen.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   host_instr/valid/ready   host -> FIFO push handshake
//   acc_instr/_valid         issued word + one-cycle strobe
//   buffer_full              accelerator back-pressure
//   accelerator_output       accelerator result bus
//   res_data/valid/ready     captured result -> host handshake
//   fifo_count               words currently queued
module acc_host_driver #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] RD_OPCODE  = 4'h5,
  parameter int         RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [63:0]                 host_instr,
  input  logic                        host_valid,
  output logic                        host_ready,
  output logic [63:0]                 acc_instr,
  output logic                        acc_instr_valid,
  input  logic                        buffer_full,
  input  logic [31:0]                 accelerator_output,
  output logic [31:0]                 res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_RD, HOLD_RES} state_t;

  state_t        r_state, w_next;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_cnt;
  logic [63:0]   r_acc_instr;
  logic          r_acc_valid;
  logic [31:0]   r_res_data;
  logic          r_res_valid;

  logic          w_push, w_pop, w_capture, w_release, w_is_rd;
  logic [63:0]   w_head;

  // A full FIFO refuses pushes even if a pop happens this cycle.
  assign host_ready = (r_count < DEPTH_C);
  assign w_push     = host_valid & host_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_is_rd    = (w_head[63:60] == RD_OPCODE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_count != '0) && !buffer_full) begin
          w_pop = 1'b1;
          if (w_is_rd) w_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // counter at zero means accelerator_output is valid this cycle
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = HOLD_RES;
        end
      end
      HOLD_RES: begin
        // exit cycle issues nothing; IDLE picks up on the next cycle
        if (r_res_valid && res_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  // Storage is not reset; occupancy is tracked by r_count/pointers only.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= host_instr;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- issue / read latency / result ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_instr <= '0;
      r_acc_valid <= 1'b0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_acc_valid <= w_pop;
      if (w_pop) r_acc_instr <= w_head;

      if (w_pop && w_is_rd)
        r_cnt <= 4'(RD_LATENCY);
      else if ((r_state == WAIT_RD) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;

      if (w_capture) begin
        r_res_data  <= accelerator_output;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign acc_instr       = r_acc_instr;
  assign acc_instr_valid = r_acc_valid;
  assign res_data        = r_res_data;
  assign res_valid       = r_res_valid;
  assign fifo_count      = r_count;

endmodule

// File: tb/tb_acc_host_driver.sv
// tb_acc_host_driver
//   Directed scenarios followed by a randomized run. A transaction-level model
//   (queue of words, absolute cycle at which a pending read result is due)
//   predicts every output each cycle; DUT outputs are sampled on the falling edge.
module tb_acc_host_driver;
  localparam int         DEPTH = 4;
  localparam logic [3:0] RDOP  = 4'h5;
  localparam int         LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] host_instr = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [63:0] acc_instr;
  logic        acc_instr_valid;
  logic        buffer_full = 1'b0;
  logic [31:0] accelerator_output = '0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  fifo_count;

  acc_host_driver #(.FIFO_DEPTH(DEPTH), .RD_OPCODE(RDOP), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .host_instr(host_instr), .host_valid(host_valid), .host_ready(host_ready),
    .acc_instr(acc_instr), .acc_instr_valid(acc_instr_valid),
    .buffer_full(buffer_full), .accelerator_output(accelerator_output),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---- reference model ----
  logic [63:0] q[$];          // words the driver holds, oldest first
  logic [63:0] pend[$];       // words the host still wants to send
  logic        hv_en = 1'b0;
  logic        m_acc_valid;
  logic [63:0] m_acc_instr;
  logic        m_res_valid;
  logic [31:0] m_res_data;
  int          m_cap_cyc;     // cycle whose accelerator_output is captured, -1 = none
  int          tcyc = 0;
  logic [31:0] cap_val = 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_acc_valid = 1'b0;
    m_acc_instr = '0;
    m_res_valid = 1'b0;
    m_res_data  = '0;
    m_cap_cyc   = -1;
  endtask

  function automatic logic [63:0] mkword(input logic [3:0] op);
    return {op, 28'($urandom), 32'($urandom)};
  endfunction

  // One clock cycle: drive, compare, advance model, move to next falling edge.
  task automatic step();
    logic        push_ok;
    logic        v;
    logic [63:0] w;
    host_valid = hv_en && (pend.size() > 0);
    host_instr = (pend.size() > 0) ? pend[0] : 64'h0;
    accelerator_output = (m_cap_cyc == tcyc) ? cap_val : 32'($urandom);
    #1;
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("host_ready", 64'(host_ready), 64'(q.size() < DEPTH));
    chk("acc_valid",  64'(acc_instr_valid), 64'(m_acc_valid));
    chk("acc_instr",  acc_instr, m_acc_instr);
    chk("res_valid",  64'(res_valid), 64'(m_res_valid));
    chk("res_data",   64'(res_data), 64'(m_res_data));
    if (!rst) begin
      model_reset();
    end else begin
      push_ok = host_valid && (q.size() < DEPTH);
      v = 1'b0;
      if (m_res_valid) begin
        if (res_ready) m_res_valid = 1'b0;
      end else if (m_cap_cyc >= 0) begin
        if (tcyc == m_cap_cyc) begin
          m_res_data  = accelerator_output;
          m_res_valid = 1'b1;
          m_cap_cyc   = -1;
        end
      end else if ((q.size() > 0) && !buffer_full) begin
        w = q.pop_front();
        m_acc_instr = w;
        v = 1'b1;
        // strobe is seen next cycle; the result is valid LAT cycles after that
        if (w[63:60] == RDOP) m_cap_cyc = tcyc + 1 + LAT;
      end
      m_acc_valid = v;
      if (push_ok) begin
        q.push_back(host_instr);
        void'(pend.pop_front());
      end
    end
    tcyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] a, x;
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);

    // reset state
    step(); step();
    chk("reset_ready", 64'(host_ready), 64'd1);
    chk("reset_count", 64'(fifo_count), 64'd0);
    rst = 1'b1;
    step();

    // three plain words issue back to back
    buffer_full = 1'b0;
    hv_en = 1'b1;
    for (int i = 0; i < 3; i++) pend.push_back(mkword(4'h1 + 4'(i)));
    a = pend[0];
    step(); step();
    chk("first_issue_A", acc_instr, a);
    for (int i = 0; i < 4; i++) step();
    chk("abc_drained", 64'(fifo_count), 64'd0);

    // back-pressure: five pushes into depth four
    buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) pend.push_back(mkword(4'h2));
    for (int i = 0; i < 4; i++) step();
    chk("full_ready", 64'(host_ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd4);
    for (int i = 0; i < 3; i++) step();
    chk("fifth_held", 64'(pend.size()), 64'd1);
    chk("no_issue_bf", 64'(acc_instr_valid), 64'd0);
    buffer_full = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("bp_drained", 64'(fifo_count), 64'd0);

    // result read with a queued word behind it
    cap_val = 32'hDEADBEEF;
    pend.push_back({RDOP, 60'h0ABC});
    x = mkword(4'h3);
    pend.push_back(x);
    for (int i = 0; i < 20 && !res_valid; i++) step();
    chk("rd_valid", 64'(res_valid), 64'd1);
    chk("rd_data",  64'(res_data), 64'hDEADBEEF);
    for (int i = 0; i < 6; i++) pend.push_back(mkword(4'h4));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_data", 64'(res_data), 64'hDEADBEEF);
    end
    chk("hold_full", 64'(fifo_count), 64'd4);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("exit_no_issue", 64'(acc_instr_valid), 64'd0);
    step();
    chk("resume_valid", 64'(acc_instr_valid), 64'd1);
    chk("resume_word",  acc_instr, x);
    hv_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    pend.delete();

    // simultaneous push/pop at count 2 across pointer wrap
    hv_en = 1'b1;
    buffer_full = 1'b1;
    pend.push_back(mkword(4'h6));
    pend.push_back(mkword(4'h7));
    step(); step();
    buffer_full = 1'b0;
    for (int i = 0; i < 10; i++) pend.push_back(mkword(4'h8 + 4'(i % 4)));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("pp_count", 64'(fifo_count), 64'd2);
    end
    hv_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    pend.delete();

    // reset while waiting for a read with two words queued
    cap_val = 32'h12345678;
    hv_en = 1'b1;
    pend.push_back({RDOP, 60'h1});
    pend.push_back(mkword(4'h1));
    pend.push_back(mkword(4'h2));
    step(); step(); step();
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_acc_instr", acc_instr, 64'h0);
    chk("rst_acc_valid", 64'(acc_instr_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  64'(res_data), 64'd0);
    chk("rst_count",     64'(fifo_count), 64'd0);
    chk("rst_ready",     64'(host_ready), 64'd1);
    model_reset();
    pend.delete();
    hv_en = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_quiet", 64'(res_valid), 64'd0);
    hv_en = 1'b1;
    pend.push_back(mkword(4'h9));
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (pend.size() < 2)
        pend.push_back(mkword(($urandom_range(0, 3) == 0) ? RDOP : 4'(($urandom_range(0, 3) == 0) ? 4'h0 : 4'hA)));
      hv_en       = ($urandom_range(0, 3) != 0);
      buffer_full = ($urandom_range(0, 3) == 0);
      res_ready   = ($urandom_range(0, 1) == 1);
      cap_val     = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
